// File: rtl/l1i_cache_if.sv
// Fetch-side and line-fill signals of the L1 instruction cache, bundled for port use.
// The cache takes the slave modport; the fetch unit / next level drive the master side.
interface l1i_cache_if;
    logic         mem_read;
    logic [31:0]  mem_address;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         l1i_hit;
    logic         pmem_read;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  mem_read, mem_address, pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, l1i_hit, pmem_read, pmem_address
    );

    modport master (
        output mem_read, mem_address, pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, l1i_hit, pmem_read, pmem_address
    );
endinterface

// File: rtl/l1i_cache.sv
// Direct-mapped, read-only L1 instruction cache with flop storage.
// Hits answer combinationally; misses fetch one 256-bit line in a single beat.
module l1i_cache #(
    parameter int unsigned S_OFFSET = 5,
    parameter int unsigned S_INDEX  = 3
) (
    input logic        clk,
    input logic        reset,
    l1i_cache_if.slave bus
);
    localparam int unsigned S_TAG = 32 - S_OFFSET - S_INDEX;
    localparam int unsigned SETS  = 1 << S_INDEX;

    typedef enum logic [0:0] {StIdle, StFetch} state_e;

    state_e                    state_q, state_d;
    logic [31:0]               miss_addr_q, miss_addr_d;
    logic [SETS-1:0]           valid_q, valid_d;
    logic [SETS-1:0][S_TAG-1:0] tag_q, tag_d;
    logic [SETS-1:0][255:0]    data_q, data_d;

    logic [S_INDEX-1:0] idx;
    logic [S_TAG-1:0]   tag;
    logic [2:0]         word;
    logic [S_INDEX-1:0] fill_idx;
    logic               hit;

    logic        mem_resp;
    logic        l1i_hit;
    logic [31:0] mem_rdata;
    logic        pmem_read;
    logic [31:0] pmem_address;

    logic unused_addr;
    assign unused_addr = ^bus.mem_address[1:0];

    assign idx      = bus.mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign tag      = bus.mem_address[31:S_OFFSET+S_INDEX];
    assign word     = bus.mem_address[4:2];
    assign fill_idx = miss_addr_q[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        mem_resp     = 1'b0;
        l1i_hit      = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_address = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.mem_read) begin
                    if (hit) begin
                        mem_resp  = 1'b1;
                        l1i_hit   = 1'b1;
                        mem_rdata = data_q[idx][{word, 5'b0} +: 32];
                    end else begin
                        miss_addr_d = {tag, idx, {S_OFFSET{1'b0}}};
                        state_d     = StFetch;
                    end
                end
            end
            StFetch: begin
                // The fill lands in the latched set regardless of what fetch does now.
                pmem_read    = 1'b1;
                pmem_address = miss_addr_q;
                if (bus.pmem_resp) begin
                    data_d[fill_idx]  = bus.pmem_rdata;
                    tag_d[fill_idx]   = miss_addr_q[31:S_OFFSET+S_INDEX];
                    valid_d[fill_idx] = 1'b1;
                    state_d           = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are silent while reset is held, including a pending fill request.
        if (reset) begin
            mem_resp     = 1'b0;
            l1i_hit      = 1'b0;
            mem_rdata    = '0;
            pmem_read    = 1'b0;
            pmem_address = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            valid_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_addr_q <= miss_addr_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
        end
    end

    assign bus.mem_resp     = mem_resp;
    assign bus.l1i_hit      = l1i_hit;
    assign bus.mem_rdata    = mem_rdata;
    assign bus.pmem_read    = pmem_read;
    assign bus.pmem_address = pmem_address;
endmodule

// File: tb/tb_l1i_cache.sv
// Directed bench for l1i_cache: cold miss, hit, conflict, flush, reset mid-fill, stream.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units after it.
module tb_l1i_cache;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    l1i_cache_if bus ();

    l1i_cache #(.S_OFFSET(5), .S_INDEX(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Full miss sequence: miss cycle, fill request held for `delay` extra cycles, then the hit.
    task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] fill_addr,
                              input logic [31:0] base, input int delay,
                              input logic [31:0] exp_word, input string name);
        step();
        bus.mem_read = 1'b1; bus.mem_address = addr; bus.pmem_resp = 1'b0;
        settle();
        checks++;
        if (bus.mem_resp !== 1'b0 || bus.l1i_hit !== 1'b0) begin
            errors++;
            $display("FAIL %s_miss_cycle: mem_resp=%b l1i_hit=%b, required 0 0", name,
                     bus.mem_resp, bus.l1i_hit);
        end
        step();
        settle();
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_address !== fill_addr || bus.mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL %s_fill_req: pmem_read=%b pmem_address=%h mem_resp=%b, required 1 %h 0",
                     name, bus.pmem_read, bus.pmem_address, bus.mem_resp, fill_addr);
        end
        for (int i = 0; i < delay; i++) begin
            step();
            settle();
            checks++;
            if (bus.pmem_read !== 1'b1 || bus.pmem_address !== fill_addr || bus.mem_resp !== 1'b0) begin
                errors++;
                $display("FAIL %s_fill_hold: pmem_read=%b pmem_address=%h mem_resp=%b, required 1 %h 0",
                         name, bus.pmem_read, bus.pmem_address, bus.mem_resp, fill_addr);
            end
        end
        bus.pmem_rdata = mk_line(base);
        bus.pmem_resp  = 1'b1;
        settle();
        checks++;
        if (bus.mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL %s_no_forward: mem_resp=%b, required 0", name, bus.mem_resp);
        end
        step();
        bus.pmem_resp = 1'b0;
        settle();
        checks++;
        if (bus.mem_resp !== 1'b1 || bus.l1i_hit !== 1'b1 || bus.mem_rdata !== exp_word ||
            bus.pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL %s_post_fill: mem_resp=%b l1i_hit=%b mem_rdata=%h pmem_read=%b, required 1 1 %h 0",
                     name, bus.mem_resp, bus.l1i_hit, bus.mem_rdata, bus.pmem_read, exp_word);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.mem_read = 1'b0; bus.mem_address = '0; bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
        step();
        step();
        settle();
        checks++;
        if (bus.mem_resp !== 1'b0 || bus.l1i_hit !== 1'b0 || bus.pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: mem_resp=%b l1i_hit=%b pmem_read=%b, required 0 0 0",
                     bus.mem_resp, bus.l1i_hit, bus.pmem_read);
        end
        step();
        reset = 1'b0;
        settle();
        checks++;
        if (bus.mem_resp !== 1'b0 || bus.l1i_hit !== 1'b0 || bus.pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL first_idle_outputs: mem_resp=%b l1i_hit=%b pmem_read=%b, required 0 0 0",
                     bus.mem_resp, bus.l1i_hit, bus.pmem_read);
        end
    endtask

    task automatic test_cold_miss();
        fetch_miss(32'h0000_0064, 32'h0000_0060, 32'h1000_0000, 4, 32'h1000_0001, "t1_cold");
    endtask

    task automatic test_hit();
        step();
        bus.mem_address = 32'h0000_007C;
        settle();
        checks++;
        if (bus.mem_resp !== 1'b1 || bus.l1i_hit !== 1'b1 || bus.mem_rdata !== 32'h1000_0007 ||
            bus.pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL t2_hit: mem_resp=%b l1i_hit=%b mem_rdata=%h pmem_read=%b, required 1 1 10000007 0",
                     bus.mem_resp, bus.l1i_hit, bus.mem_rdata, bus.pmem_read);
        end
        step();
        bus.mem_read = 1'b0;
    endtask

    task automatic test_conflict();
        fetch_miss(32'h0000_0160, 32'h0000_0160, 32'h2000_0000, 2, 32'h2000_0000, "t3_conflict");
        fetch_miss(32'h0000_0064, 32'h0000_0060, 32'h1000_0000, 1, 32'h1000_0001, "t3_reread");
        step();
        bus.mem_read = 1'b0;
    endtask

    task automatic test_flush();
        step();
        bus.mem_read = 1'b1; bus.mem_address = 32'h0000_0080;
        settle();
        checks++;
        if (bus.mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL t4_miss_cycle: mem_resp=%b, required 0", bus.mem_resp);
        end
        step();
        bus.mem_address = 32'h0000_0064;
        settle();
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h0000_0080 || bus.mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL t4_addr_change: pmem_read=%b pmem_address=%h mem_resp=%b, required 1 00000080 0",
                     bus.pmem_read, bus.pmem_address, bus.mem_resp);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            bus.mem_read = 1'b0;
            settle();
            checks++;
            if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h0000_0080) begin
                errors++;
                $display("FAIL t4_read_dropped: pmem_read=%b pmem_address=%h, required 1 00000080",
                         bus.pmem_read, bus.pmem_address);
            end
        end
        bus.pmem_rdata = mk_line(32'h3000_0000);
        bus.pmem_resp  = 1'b1;
        step();
        bus.pmem_resp = 1'b0; bus.mem_read = 1'b1; bus.mem_address = 32'h0000_0084;
        settle();
        checks++;
        if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'h3000_0001 || bus.pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL t4_set4_hit: mem_resp=%b mem_rdata=%h pmem_read=%b, required 1 30000001 0",
                     bus.mem_resp, bus.mem_rdata, bus.pmem_read);
        end
        step();
        bus.mem_address = 32'h0000_0064;
        settle();
        checks++;
        if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'h1000_0001) begin
            errors++;
            $display("FAIL t4_set3_intact: mem_resp=%b mem_rdata=%h, required 1 10000001",
                     bus.mem_resp, bus.mem_rdata);
        end
        step();
        bus.mem_read = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        step();
        bus.mem_read = 1'b1; bus.mem_address = 32'h0000_00A0;
        settle();
        step();
        settle();
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h0000_00A0) begin
            errors++;
            $display("FAIL t5_fill_req: pmem_read=%b pmem_address=%h, required 1 000000a0",
                     bus.pmem_read, bus.pmem_address);
        end
        step();
        reset = 1'b1; bus.mem_read = 1'b0;
        settle();
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.mem_resp !== 1'b0 || bus.l1i_hit !== 1'b0) begin
            errors++;
            $display("FAIL t5_during_reset: pmem_read=%b mem_resp=%b l1i_hit=%b, required 0 0 0",
                     bus.pmem_read, bus.mem_resp, bus.l1i_hit);
        end
        step();
        reset = 1'b0;
        bus.pmem_rdata = mk_line(32'h7700_0000);
        bus.pmem_resp  = 1'b1;
        settle();
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL t5_after_reset: pmem_read=%b mem_resp=%b, required 0 0",
                     bus.pmem_read, bus.mem_resp);
        end
        step();
        bus.pmem_resp = 1'b0;
        settle();
        checks++;
        if (bus.pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL t5_late_resp_idle: pmem_read=%b, required 0", bus.pmem_read);
        end
        fetch_miss(32'h0000_0084, 32'h0000_0080, 32'h4000_0000, 1, 32'h4000_0001, "t5_prior_84");
        fetch_miss(32'h0000_00A0, 32'h0000_00A0, 32'h5000_0000, 0, 32'h5000_0000, "t5_late_a0");
        step();
        bus.mem_read = 1'b0;
    endtask

    task automatic test_stream();
        int          fills;
        int          hits;
        logic [31:0] a;
        logic [31:0] exp;
        fills = 0;
        hits  = 0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int n = 0; n < 64; n++) begin
            a   = 32'(n) << 2;
            exp = 32'h6000_0000 + (a >> 2);
            step();
            bus.mem_read = 1'b1; bus.mem_address = a;
            settle();
            if (bus.mem_resp === 1'b1) begin
                hits++;
                checks++;
                if (bus.mem_rdata !== exp || bus.pmem_read !== 1'b0) begin
                    errors++;
                    $display("FAIL t6_hit_word @%h: mem_rdata=%h pmem_read=%b, required %h 0",
                             a, bus.mem_rdata, bus.pmem_read, exp);
                end
            end else begin
                fills++;
                checks++;
                if (a[4:0] !== 5'd0) begin
                    errors++;
                    $display("FAIL t6_miss_offset @%h: miss at offset %0d, required offset 0",
                             a, a[4:0]);
                end
                step();
                settle();
                checks++;
                if (bus.pmem_read !== 1'b1 || bus.pmem_address !== {a[31:5], 5'b0}) begin
                    errors++;
                    $display("FAIL t6_fill_addr @%h: pmem_read=%b pmem_address=%h, required 1 %h",
                             a, bus.pmem_read, bus.pmem_address, {a[31:5], 5'b0});
                end
                bus.pmem_rdata = mk_line(32'h6000_0000 + ({a[31:5], 5'b0} >> 2));
                bus.pmem_resp  = 1'b1;
                step();
                bus.pmem_resp = 1'b0;
                settle();
                checks++;
                if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== exp) begin
                    errors++;
                    $display("FAIL t6_fill_word @%h: mem_resp=%b mem_rdata=%h, required 1 %h",
                             a, bus.mem_resp, bus.mem_rdata, exp);
                end
            end
        end
        step();
        bus.mem_read = 1'b0;
        checks++;
        if (fills != 8) begin
            errors++;
            $display("FAIL t6_fill_count: got %0d fills, required 8", fills);
        end
        checks++;
        if (hits != 56) begin
            errors++;
            $display("FAIL t6_hit_count: got %0d zero-latency hits, required 56", hits);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush();
        test_reset_mid_fetch();
        test_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
